lsu_byte_seq: RTL and testbench

//  Load/store initiator between the execute stage and a byte-wide synchronous data RAM.

---
 rtl/lsu_byte_seq.sv | 134 +++++++++++++
 tb/tb_lsu_byte_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: serialises byte/half/word requests onto a byte-wide synchronous RAM,
// little-endian, with zero/sign extension of load results and error return for bad requests.
module lsu_byte_seq #(
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2048
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [31:0] DEPTH_L = 32'(DEPTH);

   logic [1:0]        state;
   logic [1:0]        cnt;
   logic [1:0]        size_q;
   logic [1:0]        last;
   logic              we_q;
   logic              uns_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf;
   logic              req_bad;
   logic [4:0]        cap_sh;

   always_comb begin
      req_bad = (req_size == 2'b00)
             || (req_size == 2'b10 && req_addr[0])
             || (req_size == 2'b11 && req_addr[1:0] != 2'b00)
             || (req_addr >= DEPTH_L);
   end

   always_comb begin
      case (size_q)
         2'b01:   last = 2'd0;
         2'b10:   last = 2'd1;
         default: last = 2'd3;
      endcase
   end

   // Read data lags the strobe by one cycle: lane cnt-1 in ACCESS, final lane in DRAIN.
   always_comb begin
      if (state == S_DRAIN) cap_sh = {last, 3'b000};
      else                  cap_sh = {cnt - 2'd1, 3'b000};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr[ADDR_W-1:0];
                  wdata_q <= req_wdata;
                  err_q   <= req_bad;
                  cnt     <= '0;
                  rbuf    <= '0;
                  state   <= req_bad ? S_RESP : S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!we_q && cnt != 2'd0) rbuf[cap_sh +: 8] <= mem_rdata;
               if (cnt == last) begin
                  cnt   <= '0;
                  state <= we_q ? S_RESP : S_DRAIN;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_DRAIN: begin
               rbuf[cap_sh +: 8] <= mem_rdata;
               state <= S_RESP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state so reset clears them without waiting for a clock.
   always_comb begin
      req_ready = (state == S_IDLE);
      mem_en    = (state == S_ACCESS);
      mem_we    = mem_en && we_q;
      mem_addr  = '0;
      mem_wdata = '0;
      if (mem_en) begin
         mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt};
         mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
      end
      rsp_valid = (state == S_RESP);
      rsp_err   = rsp_valid && err_q;
      rsp_rdata = '0;
      if (rsp_valid && !err_q && !we_q) begin
         case (size_q)
            2'b01:   rsp_rdata = {{24{!uns_q && rbuf[7]}}, rbuf[7:0]};
            2'b10:   rsp_rdata = {{16{!uns_q && rbuf[15]}}, rbuf[15:0]};
            default: rsp_rdata = rbuf;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Bench for lsu_byte_seq: directed cases plus random requests checked against a byte-array
// reference memory and arithmetic load/extension model.
module tb_lsu_byte_seq;

   localparam int ADDR_W = 11;
   localparam int DEPTH  = 2048;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   lsu_byte_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int vectors = 0;
   int miscompares = 0;
   int last_waits;
   logic [31:0] last_rdata;
   logic ram_clear;

   logic [7:0] ram     [0:DEPTH-1];
   logic [7:0] ref_mem [0:DEPTH-1];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] pat(int i);
      return 8'(i * 37 + 11);
   endfunction

   // Synchronous byte RAM seen by the DUT.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
         mem_rdata <= 8'h00;
      end else if (mem_en === 1'b1) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(logic [1:0] size);
      return (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
   endfunction

   function automatic bit exp_err(logic [1:0] size, logic [31:0] addr);
      return (size == 2'b00) || (size == 2'b10 && addr % 2 != 0) ||
             (size == 2'b11 && addr % 4 != 0) || (addr >= DEPTH);
   endfunction

   function automatic logic [31:0] load_val(logic [31:0] addr, int n, logic uns);
      longint v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return 32'(v);
   endfunction

   // Issues one request starting at a negedge; returns at the negedge of the response cycle.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                         input string tag);
      int n, e_lat, cyc, seen;
      bit e_err, seq_ok, idle_ok, busy_ok;
      logic [31:0] e_data;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      last_waits = 0;
      while (req_ready !== 1'b1 && last_waits < 20) begin
         @(negedge clk);
         last_waits++;
      end
      @(posedge clk);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      n = nbytes(size);
      e_err = exp_err(size, addr);
      e_lat = e_err ? 1 : (we ? n + 1 : n + 2);
      e_data = 32'h0;
      if (!e_err && we) for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
      if (!e_err && !we) e_data = load_val(addr, n, uns);
      cyc = 1; seen = 0; seq_ok = 1; idle_ok = 1; busy_ok = 1;
      while (cyc < 12) begin
         if (mem_en === 1'b1) begin
            if (mem_addr !== ADDR_W'(addr + seen) || mem_we !== we ||
                (we && mem_wdata !== 8'(wdata >> (8 * seen)))) seq_ok = 0;
            seen++;
         end else if (mem_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h00 || mem_we !== 1'b0) begin
            idle_ok = 0;
         end
         if (req_ready !== 1'b0) busy_ok = 0;
         if (rsp_valid === 1'b1) break;
         if (hold) begin
            req_addr = $urandom; req_wdata = $urandom;
            req_size = 2'($urandom); req_we = 1'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      last_rdata = rsp_rdata;
      check({tag, ".latency"}, 32'(cyc), 32'(e_lat));
      check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, e_err});
      check({tag, ".rdata"}, rsp_rdata, e_data);
      check({tag, ".accesses"}, 32'(seen), e_err ? 32'd0 : 32'(n));
      check({tag, ".byteseq"}, {31'h0, seq_ok}, 32'd1);
      check({tag, ".idle_bus"}, {31'h0, idle_ok}, 32'd1);
      check({tag, ".ready_low"}, {31'h0, busy_ok}, 32'd1);
   endtask

   initial begin
      logic [31:0] w, a;
      logic [1:0] s;
      bit ok;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
      ram_clear = 1'b1;
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset.ready", {31'h0, req_ready}, 32'd1);
      check("reset.rsp", {30'h0, rsp_valid, rsp_err}, 32'd0);
      check("reset.rdata", rsp_rdata, 32'd0);
      check("reset.mem", {mem_en, mem_we, 11'(mem_addr), mem_wdata}, 32'd0);
      ram_clear = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 0, "t1_store_word");
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, "t2_load_word");
      check("t2_word_value", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0, "t2_load_byte_s");
      check("t2_byte_s_value", last_rdata, 32'hFFFFFFDE);
      do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 0, "t2_load_byte_u");
      check("t2_byte_u_value", last_rdata, 32'h000000DE);
      do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, "t3_load_half_s");
      check("t3_half_s_value", last_rdata, 32'hFFFFDEAD);
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE1234, 0, "t3_store_half");
      @(negedge clk);
      check("t3_ram20", {24'h0, ram[32'h20]}, 32'h34);
      check("t3_ram21", {24'h0, ram[32'h21]}, 32'h12);
      check("t3_sentinel22", {24'h0, ram[32'h22]}, {24'h0, pat(32'h22)});

      do_req(1'b0, 2'b11, 1'b0, 32'h11, 32'h0, 0, "t4_word_misaligned");
      do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h5555, 0, "t4_half_misaligned");
      do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0, "t4_size0");
      do_req(1'b1, 2'b11, 1'b0, 32'(DEPTH), 32'h77, 0, "t4_word_at_depth");
      do_req(1'b0, 2'b01, 1'b1, 32'(DEPTH - 1), 32'h0, 0, "t4_last_byte_ok");

      // Reset during the third byte of a word store.
      w = $urandom;
      req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = w;
      req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5_cnt2_addr", {20'h0, 1'(mem_en), 11'(mem_addr)}, {20'h0, 1'b1, 11'h42});
      rst_n = 1'b0;
      #1;
      check("t5_mem_en_drop", {31'h0, mem_en}, 32'd0);
      check("t5_ready", {31'h0, req_ready}, 32'd1);
      check("t5_no_rsp", {31'h0, rsp_valid}, 32'd0);
      ref_mem[32'h40] = w[7:0];
      ref_mem[32'h41] = w[15:8];
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || mem_en !== 1'b0) ok = 0;
      end
      check("t5_quiet_after", {31'h0, ok}, 32'd1);
      do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, "t5_partial_load");
      do_req(1'b1, 2'b11, 1'b0, 32'h44, 32'h01020304, 0, "t5_next_store");

      // req_valid held high across a load while other req_* inputs churn.
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, "t6_first");
      do_req(1'b0, 2'b10, 1'b1, 32'h12, 32'h0, 0, "t6_second");
      check("t6_accept_wait", 32'(last_waits), 32'd1);

      for (int k = 0; k < 200; k++) begin
         s = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         case ($urandom_range(0, 9))
            0:       a = 32'(DEPTH) + $urandom_range(0, 300);
            1:       a = $urandom;
            2:       a = $urandom_range(0, DEPTH - 1);
            default: a = $urandom_range(0, 255);
         endcase
         if ($urandom_range(0, 3) != 0 && s != 2'b00) a = a & ~(32'(nbytes(s)) - 32'd1);
         do_req(1'($urandom), s, 1'($urandom), a, $urandom, 0, $sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
